// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one external memory port between instruction fetch
//             (port i, read-only) and the load/store unit (port d,
//             read/write). Data port has priority; fetch is forced through
//             after STARVE_LIMIT consecutive data grants while it waits.
//             A requester that drops valid mid-transaction (flush) is
//             parked in ABORT until the memory finishes, and the response
//             is discarded.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             i_valid/i_ready/i_addr/i_rdata
//                                      fetch port (valid held until ready)
//             d_valid/d_ready/d_addr/d_wdata/d_wstrb/d_rdata
//                                      data port, wstrb==0 means load
//             mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata
//                                      downstream memory port
//             owner                    state: 00 IDLE 01 GNT_I 10 GNT_D 11 ABORT
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_GNT_I = 2'b01;
    localparam logic [1:0] c_GNT_D = 2'b10;
    localparam logic [1:0] c_ABORT = 2'b11;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] r_state;
    logic       r_abort_port;   // 0: fetch was aborted, 1: data was aborted
    logic [3:0] r_starve;

    logic w_completing;
    logic w_arb;
    logic w_i_cand;
    logic w_d_cand;
    logic w_force_i;
    logic w_win_i;
    logic w_win_d;
    logic w_unused_abort;

    // Abort origin is held for debug visibility only; nothing downstream
    // needs it because the response is dropped regardless of port.
    assign w_unused_abort = r_abort_port;

    // A granted transaction finishing this cycle; ABORT completions do not
    // count since no re-arbitration happens on them.
    assign w_completing = mem_ready && ((r_state == c_GNT_I) || (r_state == c_GNT_D));
    assign w_arb        = (r_state == c_IDLE) || w_completing;

    // The port being served still has valid high in its completion cycle,
    // so it must be excluded or it would be granted twice.
    assign w_i_cand  = w_arb && i_valid && (r_state != c_GNT_I);
    assign w_d_cand  = w_arb && d_valid && (r_state != c_GNT_D);
    assign w_force_i = w_i_cand && (r_starve == c_STARVE_LIMIT);
    assign w_win_d   = w_d_cand && !w_force_i;
    assign w_win_i   = w_i_cand && !w_win_d;

    assign mem_valid = (r_state != c_IDLE);
    assign owner     = r_state;
    assign i_ready   = (r_state == c_GNT_I) && mem_ready;
    assign d_ready   = (r_state == c_GNT_D) && mem_ready;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_abort_port <= 1'b0;
            r_starve     <= 4'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wstrb    <= 4'd0;
        end else begin
            if (w_win_i) begin
                r_starve <= 4'd0;
            end else if (w_win_d && i_valid) begin
                if (r_starve < c_STARVE_LIMIT) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else if ((r_state == c_IDLE) && !i_valid) begin
                r_starve <= 4'd0;
            end

            if (w_win_d) begin
                r_state   <= c_GNT_D;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
            end else if (w_win_i) begin
                r_state   <= c_GNT_I;
                mem_addr  <= i_addr;
                mem_wdata <= 32'd0;
                mem_wstrb <= 4'd0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_IDLE;
                    end
                    c_GNT_I: begin
                        if (mem_ready) begin
                            r_state <= c_IDLE;
                        end else if (!i_valid) begin
                            r_state      <= c_ABORT;
                            r_abort_port <= 1'b0;
                        end
                    end
                    c_GNT_D: begin
                        if (mem_ready) begin
                            r_state <= c_IDLE;
                        end else if (!d_valid) begin
                            r_state      <= c_ABORT;
                            r_abort_port <= 1'b1;
                        end
                    end
                    c_ABORT: begin
                        // Downstream request stays driven so stores land;
                        // the late response is swallowed here.
                        if (mem_ready) begin
                            r_state <= c_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//             predicts every output on every cycle; directed scenarios add
//             literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;
    int i_pulses = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One outstanding downstream transaction at most: who owns it, whether
    // its requester has walked away, and the request that was presented.
    bit          m_started = 0;
    bit          m_active  = 0;
    bit          m_aborted = 0;
    bit          m_is_d    = 0;
    int          m_starve  = 0;
    logic [31:0] m_addr    = 0;
    logic [31:0] m_wdata   = 0;
    logic [3:0]  m_wstrb   = 0;

    task automatic model_step();
        bit finishing, want_i, want_d, give_i, give_d, idle_before;
        if (rst) begin
            m_started = 1; m_active = 0; m_aborted = 0; m_starve = 0;
            m_addr = 0; m_wdata = 0; m_wstrb = 0;
            return;
        end
        idle_before = !m_active;
        finishing   = m_active && !m_aborted && mem_ready;
        if (m_active && m_aborted) begin
            if (mem_ready) m_active = 0;
        end else if (m_active && !finishing) begin
            if (m_is_d ? !d_valid : !i_valid) m_aborted = 1;
        end else begin
            want_i = i_valid && !(finishing && !m_is_d);
            want_d = d_valid && !(finishing && m_is_d);
            give_d = want_d && !(want_i && m_starve == LIM);
            give_i = want_i && !give_d;
            if (give_i) m_starve = 0;
            else if (give_d && i_valid) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
            else if (idle_before && !i_valid) m_starve = 0;
            if (give_d) begin
                m_active = 1; m_aborted = 0; m_is_d = 1;
                m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
            end else if (give_i) begin
                m_active = 1; m_aborted = 0; m_is_d = 0;
                m_addr = i_addr; m_wdata = 0; m_wstrb = 0;
            end else begin
                m_active = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every cycle on the falling edge, away from register updates.
    initial forever begin
        @(negedge clk);
        if (i_ready === 1'b1) i_pulses++;
        if (m_started) begin
            chk("cmp_mem_valid", 32'(mem_valid), 32'(m_active));
            chk("cmp_owner", 32'(owner),
                32'(!m_active ? 2'b00 : m_aborted ? 2'b11 : m_is_d ? 2'b10 : 2'b01));
            chk("cmp_mem_addr", mem_addr, m_addr);
            chk("cmp_mem_wdata", mem_wdata, m_wdata);
            chk("cmp_mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            chk("cmp_i_ready", 32'(i_ready), 32'(m_active && !m_aborted && !m_is_d && mem_ready));
            chk("cmp_d_ready", 32'(d_ready), 32'(m_active && !m_aborted && m_is_d && mem_ready));
            chk("cmp_i_rdata", i_rdata, mem_rdata);
            chk("cmp_d_rdata", d_rdata, mem_rdata);
            chk("cmp_starve", 32'(dut.r_starve), 32'(m_starve));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1; i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wdata = 0;
        d_wstrb = 0; mem_ready = 0; mem_rdata = 0;
        step(); step();
        rst = 0;
        step();
        chk("reset_owner", 32'(owner), 32'h0);
        chk("reset_mem_valid", 32'(mem_valid), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);

        // Single fetch, memory answers two cycles after mem_valid.
        i_pulses = 0;
        i_valid = 1; i_addr = 32'h100;
        #1;
        chk("fetch_no_same_cycle_valid", 32'(mem_valid), 32'h0);
        step();
        chk("fetch_mem_valid", 32'(mem_valid), 32'h1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("fetch_owner", 32'(owner), 32'h1);
        step(); step();
        mem_ready = 1; mem_rdata = 32'h13;
        #1;
        chk("fetch_i_ready", 32'(i_ready), 32'h1);
        chk("fetch_i_rdata", i_rdata, 32'h13);
        step();
        mem_ready = 0; i_valid = 0;
        step();
        chk("fetch_pulse_count", 32'(i_pulses), 32'h1);
        chk("fetch_back_idle", 32'(owner), 32'h0);

        // Simultaneous store and fetch: store first, fetch with no gap.
        i_valid = 1; i_addr = 32'h200;
        d_valid = 1; d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = 32'hDEADBEEF;
        step();
        chk("simul_owner_d", 32'(owner), 32'h2);
        chk("simul_mem_wstrb", 32'(mem_wstrb), 32'hF);
        chk("simul_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("simul_mem_addr", mem_addr, 32'h2000);
        mem_ready = 1;
        #1;
        chk("simul_d_ready", 32'(d_ready), 32'h1);
        step();
        mem_ready = 0; d_valid = 0; d_wstrb = 0;
        chk("simul_owner_i_no_gap", 32'(owner), 32'h1);
        chk("simul_i_addr", mem_addr, 32'h200);
        chk("simul_i_wdata", mem_wdata, 32'h0);
        step();
        mem_ready = 1; mem_rdata = 32'h0000AAAA;
        #1;
        chk("simul_i_ready", 32'(i_ready), 32'h1);
        step();
        mem_ready = 0; i_valid = 0;
        step();
        chk("simul_idle", 32'(owner), 32'h0);

        // Starvation: data keeps winning from IDLE (each grant flushed and
        // re-requested) until the limit, then fetch is forced through.
        i_valid = 1; i_addr = 32'h300;
        d_valid = 1; d_addr = 32'h400; d_wstrb = 0;
        for (int k = 0; k < LIM; k++) begin
            step();
            chk($sformatf("starve_d_grant_%0d", k), 32'(owner), 32'h2);
            chk($sformatf("starve_count_%0d", k), 32'(dut.r_starve), 32'(k + 1));
            d_valid = 0;
            step();
            chk($sformatf("starve_abort_%0d", k), 32'(owner), 32'h3);
            d_valid = 1; mem_ready = 1;
            #1;
            chk($sformatf("starve_no_d_ready_%0d", k), 32'(d_ready), 32'h0);
            step();
            mem_ready = 0;
            chk($sformatf("starve_idle_%0d", k), 32'(owner), 32'h0);
        end
        step();
        chk("starve_i_forced", 32'(owner), 32'h1);
        chk("starve_i_addr", mem_addr, 32'h300);
        chk("starve_cleared", 32'(dut.r_starve), 32'h0);
        d_valid = 0;
        step();
        mem_ready = 1;
        #1;
        chk("starve_i_ready", 32'(i_ready), 32'h1);
        step();
        mem_ready = 0; i_valid = 0;
        step();

        // Abort of a load at 0x40.
        d_valid = 1; d_addr = 32'h40; d_wstrb = 0;
        step();
        chk("abort_granted", 32'(owner), 32'h2);
        d_valid = 0;
        step();
        chk("abort_owner", 32'(owner), 32'h3);
        chk("abort_mem_valid", 32'(mem_valid), 32'h1);
        chk("abort_mem_addr", mem_addr, 32'h40);
        step();
        chk("abort_holds", 32'(owner), 32'h3);
        mem_ready = 1;
        #1;
        chk("abort_no_d_ready", 32'(d_ready), 32'h0);
        chk("abort_no_i_ready", 32'(i_ready), 32'h0);
        step();
        mem_ready = 0;
        chk("abort_to_idle", 32'(owner), 32'h0);

        // Reset in the middle of a fetch.
        i_valid = 1; i_addr = 32'h500;
        step();
        chk("rstmid_granted", 32'(owner), 32'h1);
        rst = 1;
        step();
        rst = 0; i_valid = 0;
        chk("rstmid_mem_valid", 32'(mem_valid), 32'h0);
        chk("rstmid_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rstmid_owner", 32'(owner), 32'h0);
        step();
        mem_ready = 1;
        #1;
        chk("rstmid_late_i_ready", 32'(i_ready), 32'h0);
        chk("rstmid_late_d_ready", 32'(d_ready), 32'h0);
        step();
        mem_ready = 0;
        chk("rstmid_still_idle", 32'(owner), 32'h0);

        // Stray response in IDLE.
        mem_ready = 1;
        #1;
        chk("stray_i_ready", 32'(i_ready), 32'h0);
        chk("stray_d_ready", 32'(d_ready), 32'h0);
        step();
        mem_ready = 0;
        chk("stray_owner", 32'(owner), 32'h0);
        chk("stray_mem_valid", 32'(mem_valid), 32'h0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
